// File: rtl/i2c_target_datapath.sv
// rtl/i2c_target_datapath.sv - I2C target byte datapath with address match, ACK drive and TX/RX shifting
// Optional SCL/SDA majority glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module i2c_target_datapath (
   input  logic       i2c_core_clock_i,
   input  logic       reset_bit_n_i,
   input  logic       scl_i,
   input  logic       sda_i,
   input  logic [6:0] own_addr_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       sda_o,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       tx_req_o,
   output logic       nack_o,
   output logic       addr_match_o,
   output logic       rw_o,
   output logic       busy_o
);

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_ADDR_ACK, S_RX, S_RX_ACK, S_TX, S_TX_ACK, S_WAIT
   } state_t;

   state_t      r_state, w_state_nxt;
   logic        r_scl_meta, r_scl_sync, r_sda_meta, r_sda_sync;
   logic        r_scl_prev, r_sda_prev;
   logic        w_scl_s, w_sda_s;
   logic        w_scl_rise, w_scl_fall, w_start, w_stop;
   logic [7:0]  w_byte, w_tx_byte;
   logic        w_last_bit, w_addr_hit;

   logic [2:0]  r_bit_cnt, w_cnt_nxt;
   logic [6:0]  r_shift, w_shift_nxt;
   logic [7:0]  r_tx_shift, w_tx_shift_nxt;
   logic        r_ack_on, w_ack_on_nxt;
   logic        r_tx_loaded, w_tx_loaded_nxt;
   logic        r_sda, w_sda_nxt;
   logic [7:0]  r_rx_data, w_rx_data_nxt;
   logic        r_rx_valid, w_rx_valid_nxt;
   logic        r_tx_req, w_tx_req_nxt;
   logic        r_nack, w_nack_nxt;
   logic        r_match, w_match_nxt;
   logic        r_rw, w_rw_nxt;
   logic        r_busy, w_busy_nxt;

   always_ff @(posedge i2c_core_clock_i) begin
      if (!reset_bit_n_i) begin
         r_scl_meta <= 1'b1;
         r_scl_sync <= 1'b1;
         r_sda_meta <= 1'b1;
         r_sda_sync <= 1'b1;
      end else begin
         r_scl_meta <= scl_i;
         r_scl_sync <= r_scl_meta;
         r_sda_meta <= sda_i;
         r_sda_sync <= r_sda_meta;
      end
   end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
   // 2-of-3 vote over the last three synchronized samples drops single-cycle pulses.
   logic [2:0] r_scl_hist, r_sda_hist;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

   always_ff @(posedge i2c_core_clock_i) begin
      if (!reset_bit_n_i) begin
         r_scl_hist <= 3'b111;
         r_sda_hist <= 3'b111;
      end else begin
         r_scl_hist <= {r_scl_hist[1:0], r_scl_sync};
         r_sda_hist <= {r_sda_hist[1:0], r_sda_sync};
      end
   end

   assign w_scl_s = maj3(r_scl_hist);
   assign w_sda_s = maj3(r_sda_hist);
`else
   assign w_scl_s = r_scl_sync;
   assign w_sda_s = r_sda_sync;
`endif

   always_ff @(posedge i2c_core_clock_i) begin
      if (!reset_bit_n_i) begin
         r_scl_prev <= 1'b1;
         r_sda_prev <= 1'b1;
      end else begin
         r_scl_prev <= w_scl_s;
         r_sda_prev <= w_sda_s;
      end
   end

   assign w_scl_rise = w_scl_s & ~r_scl_prev;
   assign w_scl_fall = ~w_scl_s & r_scl_prev;
   assign w_start    = w_scl_s & r_scl_prev & r_sda_prev & ~w_sda_s;
   assign w_stop     = w_scl_s & r_scl_prev & ~r_sda_prev & w_sda_s;
   assign w_byte     = {r_shift, w_sda_s};
   assign w_last_bit = (r_bit_cnt == 3'd7);
   assign w_addr_hit = (w_byte[7:1] == own_addr_i);
   assign w_tx_byte  = tx_valid_i ? tx_data_i : 8'hFF;

   always_ff @(posedge i2c_core_clock_i) begin
      if (!reset_bit_n_i) r_state <= S_IDLE;
      else                r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_stop) begin
         w_state_nxt = S_IDLE;
      end else if (w_start) begin
         w_state_nxt = S_ADDR;
      end else begin
         case (r_state)
            S_ADDR:     if (w_scl_rise && w_last_bit) w_state_nxt = w_addr_hit ? S_ADDR_ACK : S_WAIT;
            S_ADDR_ACK: if (w_scl_fall && r_ack_on)   w_state_nxt = r_rw ? S_TX : S_RX;
            S_RX:       if (w_scl_rise && w_last_bit) w_state_nxt = S_RX_ACK;
            S_RX_ACK:   if (w_scl_fall && r_ack_on)   w_state_nxt = S_RX;
            S_TX:       if (w_scl_rise && w_last_bit) w_state_nxt = S_TX_ACK;
            S_TX_ACK:   if (w_scl_rise && r_ack_on)   w_state_nxt = w_sda_s ? S_WAIT : S_TX;
            default:    w_state_nxt = r_state;
         endcase
      end
   end

   // r_ack_on marks the half of an ACK slot after the first SCL fall has been seen.
   always_comb begin
      w_sda_nxt       = r_sda;
      w_cnt_nxt       = r_bit_cnt;
      w_shift_nxt     = r_shift;
      w_tx_shift_nxt  = r_tx_shift;
      w_ack_on_nxt    = r_ack_on;
      w_tx_loaded_nxt = r_tx_loaded;
      w_rx_data_nxt   = r_rx_data;
      w_rx_valid_nxt  = 1'b0;
      w_tx_req_nxt    = 1'b0;
      w_nack_nxt      = 1'b0;
      w_match_nxt     = r_match;
      w_rw_nxt        = r_rw;
      w_busy_nxt      = r_busy;
      if (w_stop) begin
         w_sda_nxt    = 1'b1;
         w_busy_nxt   = 1'b0;
         w_match_nxt  = 1'b0;
         w_ack_on_nxt = 1'b0;
      end else if (w_start) begin
         w_sda_nxt    = 1'b1;
         w_cnt_nxt    = 3'd0;
         w_busy_nxt   = 1'b1;
         w_match_nxt  = 1'b0;
         w_ack_on_nxt = 1'b0;
      end else begin
         case (r_state)
            S_ADDR, S_RX: begin
               if (w_scl_rise) begin
                  w_shift_nxt = w_byte[6:0];
                  w_cnt_nxt   = r_bit_cnt + 3'd1;
                  if (w_last_bit && r_state == S_ADDR && w_addr_hit) begin
                     w_match_nxt  = 1'b1;
                     w_rw_nxt     = w_byte[0];
                     w_tx_req_nxt = w_byte[0];
                  end else if (w_last_bit && r_state == S_RX) begin
                     w_rx_data_nxt  = w_byte;
                     w_rx_valid_nxt = 1'b1;
                  end
               end
            end
            S_ADDR_ACK, S_RX_ACK: begin
               if (w_scl_fall && !r_ack_on) begin
                  w_sda_nxt    = 1'b0;
                  w_ack_on_nxt = 1'b1;
               end else if (w_scl_fall) begin
                  w_ack_on_nxt = 1'b0;
                  w_sda_nxt    = 1'b1;
                  if (r_state == S_ADDR_ACK && r_rw) begin
                     w_sda_nxt       = w_tx_byte[7];
                     w_tx_shift_nxt  = {w_tx_byte[6:0], 1'b1};
                     w_tx_loaded_nxt = 1'b1;
                  end
               end
            end
            S_TX: begin
               if (w_scl_fall && !r_tx_loaded) begin
                  w_sda_nxt       = w_tx_byte[7];
                  w_tx_shift_nxt  = {w_tx_byte[6:0], 1'b1};
                  w_tx_loaded_nxt = 1'b1;
               end else if (w_scl_fall) begin
                  w_sda_nxt      = r_tx_shift[7];
                  w_tx_shift_nxt = {r_tx_shift[6:0], 1'b1};
               end
               if (w_scl_rise) w_cnt_nxt = r_bit_cnt + 3'd1;
            end
            S_TX_ACK: begin
               if (w_scl_fall && !r_ack_on) begin
                  w_sda_nxt    = 1'b1;
                  w_ack_on_nxt = 1'b1;
               end
               if (w_scl_rise && r_ack_on) begin
                  w_ack_on_nxt    = 1'b0;
                  w_tx_loaded_nxt = 1'b0;
                  w_nack_nxt      = w_sda_s;
                  w_tx_req_nxt    = ~w_sda_s;
               end
            end
            default: w_sda_nxt = 1'b1;
         endcase
      end
   end

   always_ff @(posedge i2c_core_clock_i) begin
      if (!reset_bit_n_i) begin
         r_sda       <= 1'b1;
         r_bit_cnt   <= 3'd0;
         r_shift     <= 7'd0;
         r_tx_shift  <= 8'hFF;
         r_ack_on    <= 1'b0;
         r_tx_loaded <= 1'b0;
         r_rx_data   <= 8'd0;
         r_rx_valid  <= 1'b0;
         r_tx_req    <= 1'b0;
         r_nack      <= 1'b0;
         r_match     <= 1'b0;
         r_rw        <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_sda       <= w_sda_nxt;
         r_bit_cnt   <= w_cnt_nxt;
         r_shift     <= w_shift_nxt;
         r_tx_shift  <= w_tx_shift_nxt;
         r_ack_on    <= w_ack_on_nxt;
         r_tx_loaded <= w_tx_loaded_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_tx_req    <= w_tx_req_nxt;
         r_nack      <= w_nack_nxt;
         r_match     <= w_match_nxt;
         r_rw        <= w_rw_nxt;
         r_busy      <= w_busy_nxt;
      end
   end

   assign sda_o        = r_sda;
   assign rx_data_o    = r_rx_data;
   assign rx_valid_o   = r_rx_valid;
   assign tx_req_o     = r_tx_req;
   assign nack_o       = r_nack;
   assign addr_match_o = r_match;
   assign rw_o         = r_rw;
   assign busy_o       = r_busy;

endmodule

// File: tb/tb_i2c_target_datapath.sv
// tb/tb_i2c_target_datapath.sv - bus-level master model with pulse scoreboard for i2c_target_datapath
module tb_i2c_target_datapath;

   localparam int H = 12;

   logic       clk = 1'b0;
   logic       resetn;
   logic       scl_m, sda_m;
   logic [6:0] own_addr;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       sda_o, rx_valid_o, tx_req_o, nack_o, addr_match_o, rw_o, busy_o;
   logic [7:0] rx_data_o;
   logic       sda_bus;

   always #5 clk = ~clk;
   assign sda_bus = sda_m & sda_o;

   i2c_target_datapath u_dut (
      .i2c_core_clock_i (clk),
      .reset_bit_n_i    (resetn),
      .scl_i            (scl_m),
      .sda_i            (sda_bus),
      .own_addr_i       (own_addr),
      .tx_data_i        (tx_data),
      .tx_valid_i       (tx_valid),
      .sda_o            (sda_o),
      .rx_data_o        (rx_data_o),
      .rx_valid_o       (rx_valid_o),
      .tx_req_o         (tx_req_o),
      .nack_o           (nack_o),
      .addr_match_o     (addr_match_o),
      .rw_o             (rw_o),
      .busy_o           (busy_o)
   );

   int n_checks = 0;
   int n_errors = 0;
   int rx_cnt, txreq_cnt, nack_cnt;
   logic sda_low_seen, busy_seen;
   logic [9:0] sb_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_pop(input logic [9:0] obs);
      logic [9:0] exp;
      exp = '0;
      if (sb_q.size() != 0) exp = sb_q.pop_front();
      check_eq("scoreboard", {22'd0, obs}, {22'd0, exp});
   endtask

   // event codes: 1 = rx byte, 2 = tx request, 3 = nack
   always @(negedge clk) begin
      if (resetn) begin
         if (!sda_o) sda_low_seen = 1'b1;
         if (busy_o) busy_seen = 1'b1;
         if (rx_valid_o) begin rx_cnt++;    sb_pop({2'd1, rx_data_o}); end
         if (tx_req_o)   begin txreq_cnt++; sb_pop({2'd2, 8'd0});      end
         if (nack_o)     begin nack_cnt++;  sb_pop({2'd3, 8'd0});      end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_counts();
      rx_cnt = 0; txreq_cnt = 0; nack_cnt = 0;
      sda_low_seen = 1'b0; busy_seen = 1'b0;
   endtask

   task automatic bus_start();
      sda_m = 1'b1; idle(H / 2);
      scl_m = 1'b1; idle(H);
      sda_m = 1'b0; idle(H);
      scl_m = 1'b0; idle(H / 2);
   endtask

   task automatic bus_stop();
      sda_m = 1'b0; idle(H / 2);
      scl_m = 1'b1; idle(H);
      sda_m = 1'b1; idle(H);
   endtask

   task automatic send_bit(input logic b);
      sda_m = b;    idle(H / 2);
      scl_m = 1'b1; idle(H);
      scl_m = 1'b0; idle(H / 2);
   endtask

   task automatic recv_bit(output logic b);
      sda_m = 1'b1; idle(H / 2);
      scl_m = 1'b1; idle(H / 2);
      b = sda_bus;  idle(H / 2);
      scl_m = 1'b0; idle(H / 2);
   endtask

   task automatic write_byte(input logic [7:0] d, output logic ack);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
      recv_bit(ack);
   endtask

   task automatic read_byte(output logic [7:0] d, input logic ack);
      logic b;
      d = '0;
      for (int i = 0; i < 8; i++) begin
         recv_bit(b);
         d = {d[6:0], b};
      end
      send_bit(ack);
   endtask

   initial begin
      logic       ack;
      logic [7:0] rd;
      logic [7:0] addr_w;
      int         waited;
      logic       exp_glitch_start;

      resetn = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
      own_addr = 7'h42; tx_data = 8'h00; tx_valid = 1'b0;
      clear_counts();
      idle(3);
      check_eq("rst_sda", sda_o, 1);
      check_eq("rst_busy", busy_o, 0);
      check_eq("rst_rx_data", rx_data_o, 0);
      check_eq("rst_match", addr_match_o, 0);
      check_eq("rst_rw", rw_o, 0);
      check_eq("rst_rx_valid", rx_valid_o, 0);
      resetn = 1'b1;
      idle(5);

      // write 0xA5 to own address
      clear_counts();
      bus_start();
      check_eq("wr_busy_on", busy_o, 1);
      write_byte(8'h84, ack);
      check_eq("wr_addr_ack", ack, 0);
      check_eq("wr_match", addr_match_o, 1);
      check_eq("wr_rw", rw_o, 0);
      sb_q.push_back({2'd1, 8'hA5});
      write_byte(8'hA5, ack);
      check_eq("wr_data_ack", ack, 0);
      check_eq("wr_rx_data", rx_data_o, 8'hA5);
      bus_stop();
      idle(5);
      check_eq("wr_busy_off", busy_o, 0);
      check_eq("wr_match_off", addr_match_o, 0);
      check_eq("wr_rx_cnt", rx_cnt, 1);

      // foreign address is ignored
      clear_counts();
      bus_start();
      write_byte(8'h86, ack);
      check_eq("miss_addr_ack", ack, 1);
      write_byte(8'h11, ack);
      check_eq("miss_data_ack", ack, 1);
      check_eq("miss_match", addr_match_o, 0);
      bus_stop();
      idle(5);
      check_eq("miss_sda_low", sda_low_seen, 0);
      check_eq("miss_pulses", rx_cnt + txreq_cnt + nack_cnt, 0);

      // read two bytes: valid 0x3C with ACK, then no valid data with NACK
      clear_counts();
      tx_data = 8'h3C; tx_valid = 1'b1;
      bus_start();
      sb_q.push_back({2'd2, 8'd0});
      write_byte(8'h85, ack);
      check_eq("rd_addr_ack", ack, 0);
      check_eq("rd_rw", rw_o, 1);
      tx_valid = 1'b0; tx_data = 8'h5A;
      sb_q.push_back({2'd2, 8'd0});
      read_byte(rd, 1'b0);
      check_eq("rd_byte0", rd, 8'h3C);
      sb_q.push_back({2'd3, 8'd0});
      read_byte(rd, 1'b1);
      check_eq("rd_byte1", rd, 8'hFF);
      bus_stop();
      idle(5);
      check_eq("rd_txreq_cnt", txreq_cnt, 2);
      check_eq("rd_nack_cnt", nack_cnt, 1);

      // repeated START after a partial byte
      clear_counts();
      bus_start();
      write_byte(8'h84, ack);
      check_eq("rs_addr_ack0", ack, 0);
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      bus_start();
      sb_q.push_back({2'd2, 8'd0});
      write_byte(8'h85, ack);
      check_eq("rs_addr_ack1", ack, 0);
      check_eq("rs_rw", rw_o, 1);
      check_eq("rs_match", addr_match_o, 1);
      bus_stop();
      idle(5);
      check_eq("rs_rx_cnt", rx_cnt, 0);

      // reset while the address ACK is being driven
      clear_counts();
      tx_data = 8'h00;
      bus_start();
      addr_w = 8'h84;
      for (int i = 7; i >= 0; i--) send_bit(addr_w[i]);
      waited = 0;
      while (sda_o !== 1'b0 && waited < 40) begin
         idle(1);
         waited++;
      end
      check_eq("ack_drive", sda_o, 0);
      resetn = 1'b0;
      idle(1);
      check_eq("rst_ack_sda", sda_o, 1);
      check_eq("rst_ack_busy", busy_o, 0);
      check_eq("rst_ack_match", addr_match_o, 0);
      check_eq("rst_ack_rx_data", rx_data_o, 0);
      resetn = 1'b1;
      idle(H);
      scl_m = 1'b1; idle(H);
      sda_m = 1'b1; idle(H);

      // single-cycle SDA low glitch while SCL is high
      clear_counts();
`ifdef I2C_TARGET_GLITCH_FILTER_EN
      exp_glitch_start = 1'b0;
`else
      exp_glitch_start = 1'b1;
`endif
      sda_m = 1'b0;
      idle(1);
      sda_m = 1'b1;
      idle(20);
      check_eq("glitch_start", busy_seen, exp_glitch_start);
      check_eq("glitch_busy_end", busy_o, 0);

      check_eq("sb_drained", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
